// File: rtl/tmr_fault_manager.sv
// tmr_fault_manager: registered 2-of-3 voter with a lane fault FSM (resync, retire, fail).
// Define TMR_ERR_COUNTER_EN to build the saturating error counter; otherwise err_count_out is 0.
//
// state    | meaning
// NORMAL   | all lanes trusted, majority vote
// SUSPECT  | one lane disagreeing, counting consecutive errors on it
// RESYNC   | resync request held on suspect lane, vote on remaining pair
// DEGRADED | suspect lane retired, vote on surviving pair, watch for failure
module tmr_fault_manager #(
  parameter int ERR_THRESH    = 4,
  parameter int RESYNC_CYCLES = 8,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_in,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             c_in,
  output logic             v_out,
  output logic             v_error_out,
  output logic [2:0]       lane_resync_out,
  output logic [2:0]       lane_dead_out,
  output logic             fail_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] err_count_out
);

  localparam int ECW = $clog2(ERR_THRESH + 1);
  localparam int TW  = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
  localparam int RW  = $clog2(MAX_RETRY + 1);
  localparam logic [ECW-1:0] THRESH   = ECW'(ERR_THRESH);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(RESYNC_CYCLES - 1);
  localparam logic [RW-1:0]  MAX_R    = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    SUSPECT  = 2'b01,
    RESYNC   = 2'b10,
    DEGRADED = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic a_r, b_r, c_r;
  logic [1:0] susp_q, susp_d;
  logic [ECW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0][RW-1:0] retry_q, retry_d;
  logic [2:0] dead_q, dead_d;
  logic fail_q, fail_d;
  logic v_hold_q;

  logic all_eq, majority, excluded, pair_x, pair_y;
  logic [1:0] odd;

  assign all_eq   = (a_r == b_r) && (b_r == c_r);
  assign majority = (a_r & b_r) | (a_r & c_r) | (b_r & c_r);
  assign excluded = (state_q == RESYNC) || (state_q == DEGRADED);

  always_comb begin
    odd = 2'd0;
    if (a_r == b_r)      odd = 2'd2;
    else if (a_r == c_r) odd = 2'd1;
    else                 odd = 2'd0;
  end

  // Surviving pair is everything except the suspect lane.
  always_comb begin
    pair_x = b_r;
    pair_y = c_r;
    case (susp_q)
      2'd0:    begin pair_x = b_r; pair_y = c_r; end
      2'd1:    begin pair_x = a_r; pair_y = c_r; end
      default: begin pair_x = a_r; pair_y = b_r; end
    endcase
  end

  always_comb begin
    v_out       = majority;
    v_error_out = !all_eq;
    if (excluded) begin
      v_error_out = pair_x ^ pair_y;
      v_out       = (pair_x == pair_y) ? pair_x : v_hold_q;
    end
  end

  always_comb begin
    state_d = state_q;
    susp_d  = susp_q;
    cnt_d   = cnt_q;
    cnt_inc = '0;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    dead_d  = dead_q;
    fail_d  = fail_q;
    case (state_q)
      NORMAL, SUSPECT: begin
        if (!all_eq) begin
          if ((state_q == SUSPECT) && (odd == susp_q)) cnt_inc = cnt_q + ECW'(1);
          else                                         cnt_inc = ECW'(1);
          susp_d = odd;
          if (cnt_inc >= THRESH) begin
            cnt_d = '0;
            if (retry_q[odd] < MAX_R) begin
              state_d      = RESYNC;
              retry_d[odd] = retry_q[odd] + RW'(1);
              tmr_d        = TMR_LOAD;
            end else begin
              state_d     = DEGRADED;
              dead_d[odd] = 1'b1;
            end
          end else begin
            state_d = SUSPECT;
            cnt_d   = cnt_inc;
          end
        end else if (state_q == SUSPECT) begin
          state_d = NORMAL;
          cnt_d   = '0;
        end
      end
      RESYNC: begin
        if (tmr_q == '0) begin
          state_d = NORMAL;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      DEGRADED: begin
        if (pair_x != pair_y) begin
          if (cnt_q < THRESH) cnt_d = cnt_q + ECW'(1);
          if (cnt_q >= THRESH - ECW'(1)) fail_d = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_in) begin
      a_r      <= 1'b0;
      b_r      <= 1'b0;
      c_r      <= 1'b0;
      state_q  <= NORMAL;
      susp_q   <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      retry_q  <= '0;
      dead_q   <= '0;
      fail_q   <= 1'b0;
      v_hold_q <= 1'b0;
    end else begin
      a_r      <= a_in;
      b_r      <= b_in;
      c_r      <= c_in;
      state_q  <= state_d;
      susp_q   <= susp_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      retry_q  <= retry_d;
      dead_q   <= dead_d;
      fail_q   <= fail_d;
      v_hold_q <= v_out;
    end
  end

  assign state_out       = state_q;
  assign lane_dead_out   = dead_q;
  assign fail_out        = fail_q;
  assign lane_resync_out = (state_q == RESYNC) ? (3'b001 << susp_q) : 3'b000;

`ifdef TMR_ERR_COUNTER_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clock) begin
    if (reset_in)                                  err_cnt_q <= '0;
    else if (v_error_out && (err_cnt_q != '1))     err_cnt_q <= err_cnt_q + CNT_W'(1);
  end

  assign err_count_out = err_cnt_q;
`else
  assign err_count_out = '0;
`endif

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Bench for tmr_fault_manager: vote table plus resync/retire/fail/reset sequences.
module tb_tmr_fault_manager;

  logic       clock = 1'b0;
  logic       reset_in = 1'b1;
  logic       a_in = 1'b0, b_in = 1'b0, c_in = 1'b0;
  logic       v_out, v_error_out, fail_out;
  logic [2:0] lane_resync_out, lane_dead_out;
  logic [1:0] state_out;
  logic [7:0] err_count_out;

`ifdef TMR_ERR_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  tmr_fault_manager dut (
    .clock(clock), .reset_in(reset_in),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .v_out(v_out), .v_error_out(v_error_out),
    .lane_resync_out(lane_resync_out), .lane_dead_out(lane_dead_out),
    .fail_out(fail_out), .state_out(state_out), .err_count_out(err_count_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic v; logic err;} exp_t;
  typedef struct {logic a; logic b; logic c; logic v; logic err;} vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected vote is produced one cycle after the lanes are driven.
  task automatic tick();
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("v_out", {31'd0, v_out}, {31'd0, e.v});
      check("v_error_out", {31'd0, v_error_out}, {31'd0, e.err});
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input logic v, input logic err);
    exp_t e;
    a_in = a; b_in = b; c_in = c;
    e.v = v; e.err = err;
    sb.push_back(e);
    tick();
  endtask

  task automatic do_reset(input int n);
    reset_in = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset_in = 1'b0;
  endtask

  // Four consecutive lane-c errors, then either a full resync or retirement.
  task automatic run_c_fault(input logic exp_dead);
    int n;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("pre_state", {30'd0, state_out}, (i == 0) ? 32'd0 : 32'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    if (!exp_dead) begin
      check("resync_state", {30'd0, state_out}, 32'd2);
      n = (lane_resync_out == 3'b100) ? 1 : 0;
      for (int k = 0; k < 20 && state_out == 2'b10; k++) begin
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        if (lane_resync_out == 3'b100) n++;
      end
      check("resync_len", n, 32'd8);
      check("post_resync_state", {30'd0, state_out}, 32'd0);
      check("post_resync_req", {29'd0, lane_resync_out}, 32'd0);
    end else begin
      check("degraded_state", {30'd0, state_out}, 32'd3);
      check("dead_lane", {29'd0, lane_dead_out}, 32'd4);
      check("degraded_no_resync", {29'd0, lane_resync_out}, 32'd0);
    end
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // reset state
    do_reset(2);
    check("rst_v", {31'd0, v_out}, 32'd0);
    check("rst_err", {31'd0, v_error_out}, 32'd0);
    check("rst_resync", {29'd0, lane_resync_out}, 32'd0);
    check("rst_dead", {29'd0, lane_dead_out}, 32'd0);
    check("rst_fail", {31'd0, fail_out}, 32'd0);
    check("rst_state", {30'd0, state_out}, 32'd0);
    check("rst_errcnt", {24'd0, err_count_out}, 32'd0);

    // all agree, one-cycle latency
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("agree_state", {30'd0, state_out}, 32'd0);

    // vote table
    for (int i = 0; i < 9; i++) drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].v, vecs[i].err);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("table_end_state", {30'd0, state_out}, 32'd0);
    check("table_no_resync", {29'd0, lane_resync_out}, 32'd0);

    // transient on lane b
    do_reset(1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("tr_state1", {30'd0, state_out}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("tr_state2", {30'd0, state_out}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("tr_state3", {30'd0, state_out}, 32'd1);
    check("tr_no_resync", {29'd0, lane_resync_out}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("tr_state4", {30'd0, state_out}, 32'd0);
    check("tr_errcnt", {24'd0, err_count_out}, CNT_EN ? 32'd2 : 32'd0);

    // single resync on lane c
    run_c_fault(1'b0);

    // retire lane c on the fourth fault, then surviving pair disagrees
    do_reset(1);
    for (int r = 0; r < 3; r++) run_c_fault(1'b0);
    run_c_fault(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("deg_state", {30'd0, state_out}, 32'd3);
      check("fail_early", {31'd0, fail_out}, 32'd0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("fail_set", {31'd0, fail_out}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("fail_sticky", {31'd0, fail_out}, 32'd1);
    check("dead_sticky", {29'd0, lane_dead_out}, 32'd4);

    // reset during resync clears retries
    do_reset(1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mid_resync_state", {30'd0, state_out}, 32'd2);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mid_resync_req", {29'd0, lane_resync_out}, 32'd4);
    do_reset(1);
    check("rr_resync", {29'd0, lane_resync_out}, 32'd0);
    check("rr_state", {30'd0, state_out}, 32'd0);
    check("rr_dead", {29'd0, lane_dead_out}, 32'd0);
    for (int r = 0; r < 3; r++) run_c_fault(1'b0);
    run_c_fault(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
